// File: rtl/mem_wb_skid_stage_if.sv
// mem_wb_skid_stage_if: MEM->WB handshake, payload and write-back bundle
interface mem_wb_skid_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              flush_i;
  logic              valid_i;
  logic              ready_o;
  logic [1:0]        WB_i;
  logic [DATA_W-1:0] ReadData_i;
  logic [DATA_W-1:0] addr_i;
  logic [REG_AW-1:0] MUX3_i;
  logic              valid_o;
  logic              ready_i;
  logic              RegWrite_o;
  logic              MemToReg_o;
  logic [DATA_W-1:0] ReadData_o;
  logic [DATA_W-1:0] addr_o;
  logic [REG_AW-1:0] MUX3_o;
  logic [DATA_W-1:0] WriteData_o;
  logic [1:0]        count_o;
  modport slave (
    input  flush_i, valid_i, WB_i, ReadData_i, addr_i, MUX3_i, ready_i,
    output ready_o, valid_o, RegWrite_o, MemToReg_o, ReadData_o, addr_o, MUX3_o, WriteData_o, count_o
  );
  modport master (
    output flush_i, valid_i, WB_i, ReadData_i, addr_i, MUX3_i, ready_i,
    input  ready_o, valid_o, RegWrite_o, MemToReg_o, ReadData_o, addr_o, MUX3_o, WriteData_o, count_o
  );
endinterface

// File: rtl/mem_wb_skid_stage.sv
// mem_wb_skid_stage: MEM/WB pipeline register with 2-entry skid buffer and write-back mux
module mem_wb_skid_stage #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter bit ZERO_SQUASH = 1'b1
) (
  input logic clk_i,
  input logic rst_i,
  mem_wb_skid_stage_if.slave bus
);
  typedef struct packed {
    logic [1:0]        wb;
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] addr;
    logic [REG_AW-1:0] idx;
  } entry_t;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t state;
  entry_t head, skid, in_e;
  logic head_v, acc, rel;
  assign in_e   = '{wb: bus.WB_i, rd: bus.ReadData_i, addr: bus.addr_i, idx: bus.MUX3_i};
  assign head_v = state != EMPTY;
  // ready depends on registered state only, so no ready_i -> ready_o path
  assign bus.ready_o = state != TWO;
  assign acc = bus.valid_i & bus.ready_o;
  assign rel = head_v & bus.ready_i;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
    end else if (bus.flush_i) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: if (acc) begin
          head  <= in_e;
          state <= ONE;
        end
        ONE: if (acc && rel) head <= in_e;
          else if (acc) begin
            skid  <= in_e;
            state <= TWO;
          end else if (rel) state <= EMPTY;
        TWO: if (rel) begin
          head  <= skid;
          state <= ONE;
        end
        default: state <= EMPTY;
      endcase
    end
  end
  assign bus.valid_o     = head_v;
  assign bus.count_o     = state;
  assign bus.RegWrite_o  = head_v & head.wb[1] & ~(ZERO_SQUASH && head.idx == '0);
  assign bus.MemToReg_o  = head_v & head.wb[0];
  assign bus.ReadData_o  = head.rd;
  assign bus.addr_o      = head.addr;
  assign bus.MUX3_o      = head.idx;
  assign bus.WriteData_o = bus.MemToReg_o ? head.rd : head.addr;
endmodule
